// File: rtl/seg_display_driver.sv
// Six-digit common-anode seven-segment scanner for a {sign, 5 x BCD} word.
// The word is latched once per frame so a digit never tears mid-scan.

module seg_digit_dec (
  input  logic [3:0] nib,
  output logic [6:0] pat
);
  always_comb begin
    unique case (nib)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b0000110; // "E" for non-decimal nibbles
    endcase
  end
endmodule

module seg_display_driver #(
  parameter int unsigned prescale = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [20:0] data_in,
  input  logic        blank,
  output logic [6:0]  seg,
  output logic [5:0]  an,
  output logic        frame
);
  localparam int          NUM_DIGITS = 5;
  localparam logic [15:0] PCNT_MAX   = 16'(prescale - 1);
  localparam logic [6:0]  SEG_OFF    = 7'b1111111;
  localparam logic [6:0]  SEG_MINUS  = 7'b0111111;

  logic [15:0]                 pcnt;
  logic [2:0]                  idx;
  logic [20:0]                 frame_buf;
  logic [NUM_DIGITS-1:0][6:0]  dig_pat;
  logic [NUM_DIGITS-1:0][6:0]  dig_glyph;
  logic                        any_nz;
  logic                        tick;
  logic [6:0]                  glyph;

  genvar k;
  generate
    for (k = 0; k < NUM_DIGITS; k++) begin : g_dec
      seg_digit_dec u_dec (.nib(frame_buf[4*k +: 4]), .pat(dig_pat[k]));
    end
  endgenerate

  // Walk from the most significant digit down; a digit stays lit once
  // it or anything above it is nonzero. The ones digit is always lit.
  always_comb begin
    any_nz    = 1'b0;
    dig_glyph = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      any_nz       = any_nz | (|frame_buf[4*i +: 4]);
      dig_glyph[i] = (any_nz || i == 0) ? dig_pat[i] : SEG_OFF;
    end
  end

  always_comb begin
    glyph = SEG_OFF;
    case (idx)
      3'd0: glyph = dig_glyph[0];
      3'd1: glyph = dig_glyph[1];
      3'd2: glyph = dig_glyph[2];
      3'd3: glyph = dig_glyph[3];
      3'd4: glyph = dig_glyph[4];
      3'd5: glyph = (frame_buf[20] && any_nz) ? SEG_MINUS : SEG_OFF;
      default: glyph = SEG_OFF;
    endcase
  end

  assign tick = (pcnt == PCNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt      <= '0;
      idx       <= '0;
      frame_buf <= '0;
      an        <= '1;
      seg       <= SEG_OFF;
      frame     <= 1'b0;
    end else begin
      frame <= 1'b0;
      if (tick) begin
        // Dead cycle: anodes off while idx advances, segments hold.
        pcnt <= '0;
        an   <= '1;
        if (idx == 3'd5) begin
          idx       <= '0;
          frame_buf <= data_in;
          frame     <= 1'b1;
        end else begin
          idx <= idx + 3'd1;
        end
      end else begin
        pcnt <= pcnt + 16'd1;
        if (pcnt == 16'd0) begin
          an  <= blank ? 6'b111111 : ~(6'b000001 << idx);
          seg <= glyph;
        end
      end
    end
  end
endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver at prescale = 4 (24-cycle frame).

module tb_seg_display_driver;
  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100,
                         D3 = 7'b0110000, D4 = 7'b0011001, D5 = 7'b0010010,
                         BL = 7'b1111111, MI = 7'b0111111, ER = 7'b0000110;

  logic        clk = 1'b0;
  logic        rst;
  logic [20:0] data_in;
  logic        blank;
  logic [6:0]  seg;
  logic [5:0]  an;
  logic        frame;

  int total = 0;
  int fails = 0;

  seg_display_driver #(.prescale(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .blank(blank),
    .seg(seg), .an(an), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    do begin
      step(1);
      n++;
    end while (frame !== 1'b1 && n < 60);
    chk({tag, " frame seen"}, 32'(frame), 32'd1);
  endtask

  // Called on the negedge right after a frame pulse. Checks one full
  // frame; g is {idx5..idx0}. data_in switches to nxt at slot chg.
  task automatic show_frame(input string tag, input logic [5:0][6:0] g,
                            input logic [20:0] nxt, input int chg);
    logic [5:0] exp_an;
    for (int i = 0; i < 6; i++) begin
      if (i == chg) data_in = nxt;
      exp_an = ~(6'b000001 << i);
      step(1);
      chk($sformatf("%s slot%0d an", tag, i), 32'(an), 32'(exp_an));
      chk($sformatf("%s slot%0d seg", tag, i), 32'(seg), 32'(g[i]));
      step(2);
      chk($sformatf("%s slot%0d an hold", tag, i), 32'(an), 32'(exp_an));
      step(1);
      chk($sformatf("%s slot%0d dead", tag, i), 32'(an), 32'h3f);
      chk($sformatf("%s slot%0d frame", tag, i), 32'(frame), (i == 5) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0; data_in = '0; blank = 1'b0;
    step(3);
    chk("reset an", 32'(an), 32'h3f);
    chk("reset seg", 32'(seg), 32'(BL));
    chk("reset frame", 32'(frame), 32'd0);

    rst = 1'b1;
    step(1);
    chk("release an", 32'(an), 32'h3e);
    chk("release seg", 32'(seg), 32'(D0));
    data_in = {1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    step(22);
    chk("first latch early", 32'(frame), 32'd0);
    step(1);
    chk("first latch", 32'(frame), 32'd1);

    show_frame("scan", {BL, D1, D2, D3, D4, D5}, {1'b1, 4'd0, 4'd0, 4'd0, 4'd4, 4'd2}, 0);
    show_frame("neg42", {MI, BL, BL, BL, D4, D2}, {1'b1, 20'h00000}, 0);
    show_frame("negzero", {BL, BL, BL, BL, BL, D0}, {1'b0, 20'h11111}, 0);
    show_frame("hold1", {BL, D1, D1, D1, D1, D1}, {1'b0, 20'h22222}, 2);
    show_frame("new2", {BL, D2, D2, D2, D2, D2}, {1'b0, 20'h0000C}, 0);
    show_frame("errE", {BL, BL, BL, BL, BL, ER}, {1'b0, 20'h0000C}, 6);

    // blank raised mid slot 0: current slot holds, later drives stay dark
    step(2);
    blank = 1'b1;
    step(1);
    chk("blank mid-slot hold", 32'(an), 32'h3e);
    step(1);
    chk("blank dead", 32'(an), 32'h3f);
    step(1);
    chk("blank slot1", 32'(an), 32'h3f);
    step(4);
    chk("blank slot2", 32'(an), 32'h3f);
    blank = 1'b0;
    step(4);
    chk("unblank slot3", 32'(an), 32'h37);

    // reset in the middle of slot 3
    step(1);
    rst = 1'b0;
    step(1);
    chk("midrst an", 32'(an), 32'h3f);
    chk("midrst seg", 32'(seg), 32'(BL));
    chk("midrst frame", 32'(frame), 32'd0);
    rst = 1'b1;
    step(1);
    chk("postrst an", 32'(an), 32'h3e);
    chk("postrst seg", 32'(seg), 32'(D0));
    step(4);
    chk("postrst slot1 an", 32'(an), 32'h3d);
    chk("postrst slot1 seg", 32'(seg), 32'(BL));
    step(19);
    chk("postrst latch", 32'(frame), 32'd1);
    step(1);
    chk("postrst new seg", 32'(seg), 32'(ER));
    chk("postrst new an", 32'(an), 32'h3e);

    wait_frame("final");

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
